trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Sits directly upstream of the privilege/CSR unit. Decides when a trap (exception or interrupt) or an xRET is taken, and drains the pipeline.
- Drives the one-cycle handle_interrupt / handle_exception / handle_mret / handle_sret strobes with save_pc, save_priv and exception_code.
- Redirects fetch to the trap handler or to xEPC, and owns the current privilege register.

Parameters:
- REG_WIDTH, 64, datapath/CSR width
- DRAIN_MAX, 15, max cycles spent in DRAIN before forcing the commit; counter width is clog2(DRAIN_MAX+1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- exc_valid  in  1  oldest instruction raised a synchronous exception
- exc_code  in  63  exception cause
- exc_pc  in  REG_WIDTH  PC of the faulting instruction
- commit_pc  in  REG_WIDTH  PC of the next instruction to commit (interrupt return point)
- mip_csr  in  REG_WIDTH  pending interrupt bits
- mie_csr  in  REG_WIDTH  interrupt enable bits
- mstatus_mie  in  1  global M interrupt enable
- mstatus_mpp  in  2  mstatus.MPP
- sstatus_spp  in  1  sstatus.SPP
- mtvec_csr  in  REG_WIDTH  trap vector (base[63:2], mode[1:0])
- mepc_csr  in  REG_WIDTH  mret target
- sepc_csr  in  REG_WIDTH  sret target
- mret_valid  in  1  mret at commit
- sret_valid  in  1  sret at commit
- pipe_empty  in  1  no in-flight instructions behind the flush point
- flush  out  1  one-cycle pipeline flush
- stall_fetch  out  1  hold fetch while sequencing
- handle_interrupt  out  1  strobe to CSR unit
- handle_exception  out  1  strobe to CSR unit
- handle_mret  out  1  strobe to CSR unit
- handle_sret  out  1  strobe to CSR unit
- save_pc  out  REG_WIDTH  xEPC value
- save_priv  out  2  privilege before the trap
- exception_code  out  63  cause (MSB interrupt flag is added by the CSR unit)
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  REG_WIDTH  new fetch PC
- priv_out  out  2  current privilege
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (reset==0, async): state=IDLE, priv_out=2'b11 (M), drain counter=0. All strobes, flush, stall_fetch, redirect_valid and busy are 0. save_pc, save_priv, exception_code and redirect_pc are 0.
- Interrupt eligibility: irq = mip_csr & mie_csr, masked to bits {11,3,7,9,1,5}. An interrupt is takeable when irq != 0 and (priv_out != M or mstatus_mie).
- Fixed interrupt priority: 11 > 3 > 7 > 9 > 1 > 5. Cause = selected bit index.
- IDLE acceptance priority, evaluated in the same cycle: exc_valid > takeable interrupt > mret_valid > sret_valid.
  - The loser of a simultaneous event is dropped; it is replayed after the flush.
- On acceptance, in the same edge, latch:
  - kind (EXC/IRQ/MRET/SRET)
  - save_pc: exc_pc for EXC, commit_pc for IRQ
  - save_priv = priv_out
  - exception_code: exc_code for EXC, zero-extended index for IRQ
  - ret target priv: mstatus_mpp for MRET, {1'b0, sstatus_spp} for SRET. Latched here because the CSR unit overwrites MPP/SPP on the strobe edge.
- FSM IDLE -> DRAIN on acceptance. flush=1 for exactly the first DRAIN cycle. stall_fetch=1 and busy=1 in all non-IDLE states.
- DRAIN -> COMMIT when pipe_empty=1, or when the drain counter reaches DRAIN_MAX (forced). The counter clears on entry to DRAIN.
- COMMIT (1 cycle): exactly one of handle_exception / handle_interrupt / handle_mret / handle_sret = 1, chosen by kind. save_pc, save_priv and exception_code hold the latched values.
- COMMIT -> REDIRECT. REDIRECT (1 cycle): redirect_valid=1, then go to IDLE.
  - EXC: redirect_pc = {mtvec[63:2], 2'b00}.
  - IRQ with mtvec[1:0]==1: base + 4*cause (64-bit add, wrap ignored). IRQ otherwise: base.
  - MRET: redirect_pc = mepc_csr. SRET: redirect_pc = sepc_csr.
- priv_out updates on the REDIRECT edge: EXC/IRQ -> 2'b11; MRET/SRET -> latched target priv.
- Inputs arriving outside IDLE are ignored. No event is accepted in the REDIRECT cycle.
- Minimum trap latency, acceptance to redirect_valid, is 3 cycles (pipe_empty already 1 in DRAIN).
- Reset asserted mid-sequence aborts immediately to the reset state. No partial strobe is emitted.

Test Plan:
- exc_valid=1, exc_code=2, exc_pc=0x8000_0010, mtvec=0x8000_1001, priv=M, pipe_empty=1 -> flush for 1 cycle; next cycle handle_exception=1, save_pc=0x8000_0010, code=2; next cycle redirect_pc=0x8000_1000; priv_out=3.
- mip=mie=0x880 (bits 7 and 11), mstatus_mie=1, mtvec=0x8000_1001, commit_pc=0x100 -> handle_interrupt with code=11, save_pc=0x100; redirect_pc=0x8000_102C.
- Same interrupt with mstatus_mie=0, priv=M -> no acceptance, busy stays 0. Set priv to U via an mret with mpp=0 -> interrupt is taken and save_priv=0.
- mret_valid=1, mstatus_mpp=0, mepc=0x4000 -> handle_mret pulse, redirect_pc=0x4000, priv_out=0 after REDIRECT, even though mpp changes on the strobe edge.
- exc_valid and mret_valid in the same cycle -> only handle_exception fires. pipe_empty held 0 -> COMMIT forced exactly DRAIN_MAX cycles after DRAIN entry.
- reset pulsed low during DRAIN -> all outputs 0, priv_out=3. No handle_* strobe is seen afterwards.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap/xRET sequencer: accepts exceptions, interrupts and returns,
// drains the pipeline, strobes the CSR unit and redirects fetch.
module trap_sequencer #(
   parameter int REG_WIDTH = 64,
   parameter int DRAIN_MAX = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 exc_valid,
   input  logic [62:0]          exc_code,
   input  logic [REG_WIDTH-1:0] exc_pc,
   input  logic [REG_WIDTH-1:0] commit_pc,
   input  logic [REG_WIDTH-1:0] mip_csr,
   input  logic [REG_WIDTH-1:0] mie_csr,
   input  logic                 mstatus_mie,
   input  logic [1:0]           mstatus_mpp,
   input  logic                 sstatus_spp,
   input  logic [REG_WIDTH-1:0] mtvec_csr,
   input  logic [REG_WIDTH-1:0] mepc_csr,
   input  logic [REG_WIDTH-1:0] sepc_csr,
   input  logic                 mret_valid,
   input  logic                 sret_valid,
   input  logic                 pipe_empty,
   output logic                 flush,
   output logic                 stall_fetch,
   output logic                 handle_interrupt,
   output logic                 handle_exception,
   output logic                 handle_mret,
   output logic                 handle_sret,
   output logic [REG_WIDTH-1:0] save_pc,
   output logic [1:0]           save_priv,
   output logic [62:0]          exception_code,
   output logic                 redirect_valid,
   output logic [REG_WIDTH-1:0] redirect_pc,
   output logic [1:0]           priv_out,
   output logic                 busy
);

   localparam int CW = $clog2(DRAIN_MAX + 1);

   typedef enum logic [1:0] {
      IDLE, DRAIN, COMMIT, REDIRECT
   } state_t;

   typedef enum logic [1:0] {
      K_EXC, K_IRQ, K_MRET, K_SRET
   } kind_t;

   state_t               state_q, state_d;
   kind_t                kind_q, kind_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [REG_WIDTH-1:0] pc_q;
   logic [1:0]           spriv_q;
   logic [62:0]          code_q;
   logic [1:0]           rpriv_q;
   logic [1:0]           priv_q;

   logic [REG_WIDTH-1:0] irq_all;
   logic                 irq_any;
   logic                 irq_take;
   logic [3:0]           irq_idx;
   logic                 accept;
   logic                 unused_irq;

   assign irq_all = mip_csr & mie_csr;
   assign unused_irq = ^{irq_all[REG_WIDTH-1:12], irq_all[10],
                         irq_all[8], irq_all[6], irq_all[4],
                         irq_all[2], irq_all[0]};

   // Fixed priority 11 > 3 > 7 > 9 > 1 > 5
   always_comb begin
      irq_any = 1'b1;
      irq_idx = 4'd0;
      if (irq_all[11])     irq_idx = 4'd11;
      else if (irq_all[3]) irq_idx = 4'd3;
      else if (irq_all[7]) irq_idx = 4'd7;
      else if (irq_all[9]) irq_idx = 4'd9;
      else if (irq_all[1]) irq_idx = 4'd1;
      else if (irq_all[5]) irq_idx = 4'd5;
      else                 irq_any = 1'b0;
   end

   assign irq_take = irq_any && ((priv_q != 2'b11) || mstatus_mie);

   always_comb begin
      accept = 1'b0;
      kind_d = kind_q;
      if (state_q == IDLE) begin
         if (exc_valid) begin
            accept = 1'b1;
            kind_d = K_EXC;
         end else if (irq_take) begin
            accept = 1'b1;
            kind_d = K_IRQ;
         end else if (mret_valid) begin
            accept = 1'b1;
            kind_d = K_MRET;
         end else if (sret_valid) begin
            accept = 1'b1;
            kind_d = K_SRET;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + CW'(1);
            if (pipe_empty || (cnt_q == CW'(DRAIN_MAX - 1)))
               state_d = COMMIT;
         end
         COMMIT:   state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         kind_q  <= K_EXC;
         cnt_q   <= '0;
         pc_q    <= '0;
         spriv_q <= 2'b00;
         code_q  <= '0;
         rpriv_q <= 2'b00;
         priv_q  <= 2'b11;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            kind_q  <= kind_d;
            spriv_q <= priv_q;
            case (kind_d)
               K_EXC: begin
                  pc_q   <= exc_pc;
                  code_q <= exc_code;
               end
               K_IRQ: begin
                  pc_q   <= commit_pc;
                  code_q <= {59'd0, irq_idx};
               end
               // MPP/SPP are rewritten on the strobe edge
               K_MRET:  rpriv_q <= mstatus_mpp;
               default: rpriv_q <= {1'b0, sstatus_spp};
            endcase
         end
         if (state_q == REDIRECT) begin
            if (kind_q == K_EXC || kind_q == K_IRQ)
               priv_q <= 2'b11;
            else
               priv_q <= rpriv_q;
         end
      end
   end

   logic [REG_WIDTH-1:0] base;
   logic [REG_WIDTH-1:0] vec;

   assign base = {mtvec_csr[REG_WIDTH-1:2], 2'b00};
   assign vec  = base + {{(REG_WIDTH-6){1'b0}}, code_q[3:0], 2'b00};

   always_comb begin
      flush            = 1'b0;
      handle_exception = 1'b0;
      handle_interrupt = 1'b0;
      handle_mret      = 1'b0;
      handle_sret      = 1'b0;
      redirect_valid   = 1'b0;
      redirect_pc      = '0;
      busy             = (state_q != IDLE);
      stall_fetch      = (state_q != IDLE);
      case (state_q)
         DRAIN: flush = (cnt_q == '0);
         COMMIT: begin
            handle_exception = (kind_q == K_EXC);
            handle_interrupt = (kind_q == K_IRQ);
            handle_mret      = (kind_q == K_MRET);
            handle_sret      = (kind_q == K_SRET);
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            case (kind_q)
               K_EXC:  redirect_pc = base;
               K_IRQ:  redirect_pc = (mtvec_csr[1:0] == 2'b01) ? vec : base;
               K_MRET: redirect_pc = mepc_csr;
               default: redirect_pc = sepc_csr;
            endcase
         end
         default: ;
      endcase
   end

   assign save_pc        = pc_q;
   assign save_priv      = spriv_q;
   assign exception_code = code_q;
   assign priv_out       = priv_q;

endmodule
